// File: rtl/out_ser_pkg.sv
// out_ser_pkg: shared types and constants for the output serializer.
//   out_ser_state_t  : FSM state encoding (S_IDLE, S_SHIFT)
//   cnt_w()          : bit-counter width for a given word width
//   OUT_SER_IDLE_VAL : default level on dout between frames
package out_ser_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } out_ser_state_t;

    localparam logic OUT_SER_IDLE_VAL = 1'b0;

    // Counter must index 0..width-1; a 1-bit counter still covers width 2.
    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/out_ser_if.sv
// out_ser_if: parallel-word valid/ready handshake into the serializer.
//   din       : parallel word
//   din_valid : din is valid
//   din_ready : serializer accepts din this cycle
interface out_ser_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (output din, output din_valid, input  din_ready);
    modport slave  (input  din, input  din_valid, output din_ready);
endinterface

// File: rtl/out_ser_shreg.sv
// out_ser_shreg: loadable shift register holding the word being serialized.
//   clk_i, rst_n_i : clock, async active-low reset (clears to 0)
//   load_i         : capture data_i (wins over en_i)
//   en_i           : shift one position toward the output end
//   data_i         : parallel word
//   next_o         : bit that follows the one currently on dout
module out_ser_shreg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             next_o
);

    logic [WIDTH-1:0] sr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (en_i) begin
            sr_q <= MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
        end
    end

    // The head bit is already sitting in the dout flop, so the tap is one
    // position behind it.
    assign next_o = MSB_FIRST ? sr_q[WIDTH-2] : sr_q[1];

endmodule

// File: rtl/out_ser.sv
// out_ser: parallel-to-serial output serializer feeding the output-IO OQI.
//   IQC   : clock, rising edge
//   QRT   : async active-low reset
//   s_if  : din / din_valid / din_ready handshake (slave side)
//   hold  : freezes shifting while in SHIFT
//   dout  : registered serial bit
//   busy  : a word is being shifted
//   done  : one-cycle pulse after the last bit of each word
//
// state   | meaning
// S_IDLE  | no word in flight, dout = IDLE_VAL, ready for a word
// S_SHIFT | word in flight, cnt_q = index of the bit on dout
module out_ser
    import out_ser_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_VAL  = OUT_SER_IDLE_VAL
) (
    input  logic     IQC,
    input  logic     QRT,
    out_ser_if.slave s_if,
    input  logic     hold,
    output logic     dout,
    output logic     busy,
    output logic     done
);

    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    out_ser_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dout_q, dout_d;
    logic           busy_q;
    logic           done_q, done_d;
    logic           load, shift_en, next_bit, first_bit;
    logic           ready, accept;

    assign first_bit = MSB_FIRST ? s_if.din[WIDTH-1] : s_if.din[0];

    // Ready on the last bit lets the next word follow with no idle gap.
    assign ready          = (state_q == S_IDLE) || ((cnt_q == CNT_LAST) && !hold);
    assign accept         = s_if.din_valid && ready;
    assign s_if.din_ready = ready;

    out_ser_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk_i   (IQC),
        .rst_n_i (QRT),
        .load_i  (load),
        .en_i    (shift_en),
        .data_i  (s_if.din),
        .next_o  (next_bit)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                dout_d = IDLE_VAL;
                if (accept) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    dout_d  = first_bit;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!hold) begin
                    if (cnt_q == CNT_LAST) begin
                        done_d = 1'b1;
                        if (accept) begin
                            load   = 1'b1;
                            cnt_d  = '0;
                            dout_d = first_bit;
                        end else begin
                            state_d = S_IDLE;
                            dout_d  = IDLE_VAL;
                        end
                    end else begin
                        shift_en = 1'b1;
                        dout_d   = next_bit;
                        cnt_d    = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                dout_d  = IDLE_VAL;
            end
        endcase
    end

    always_ff @(posedge IQC or negedge QRT) begin
        if (!QRT) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dout_q  <= IDLE_VAL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            busy_q  <= (state_d == S_SHIFT);
            done_q  <= done_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/out_ser.md
# out_ser

Output serializer for the AP3 output I/O path. Accepts a parallel word on a valid/ready handshake and shifts it out one bit per clock on a registered serial line. That line drives the `OQI` data input of the output-IO cell, which buffers it onto the pad. The block replaces a bare output register where a fabric word must leave the chip as a serial stream with gap-free back-to-back frames.

## Interface
- `WIDTH`, default 8: bits per word; legal range is 2..32.
- `MSB_FIRST`, default 1: 1 shifts bit `WIDTH-1` first; 0 shifts bit 0 first.
- `IDLE_VAL`, default 0: level driven on `dout` when no word is shifting.

Ports:
- `IQC` input, 1 bit: clock, rising edge.
- `QRT` input, 1 bit: reset, asynchronous, active-low.
- `din` input, `WIDTH` bits: parallel word.
- `din_valid` input, 1 bit: `din` is valid.
- `din_ready` output, 1 bit: the block accepts `din` this cycle.
- `hold` input, 1 bit: freezes shifting (clock-enable, active-high).
- `dout` output, 1 bit: registered serial bit; feeds the output-IO `OQI`.
- `busy` output, 1 bit: a word is being shifted.
- `done` output, 1 bit: one-cycle pulse after the last bit of a word.

## Operation
- There are two states, IDLE and SHIFT, held in a state register, a `WIDTH`-bit shift register and a bit counter of `$clog2(WIDTH)` bits.
- **Accept:** a word is accepted when `din_valid && din_ready` is sampled on a rising edge.
- **`din_ready` (combinational, no dependence on `din_valid`):**
  - 1 in IDLE.
  - 1 in SHIFT when the counter equals `WIDTH-1` and `hold` is 0.
  - 0 otherwise.
- **IDLE → SHIFT on accept:**
  - Load the shift register with `din`.
  - Counter := 0.
  - `dout` := first bit (`din[WIDTH-1]` when `MSB_FIRST`, else `din[0]`).
- **SHIFT, `hold` = 0, counter < `WIDTH-1`:**
  - Shift one position.
  - `dout` := next bit.
  - Counter increments.
- **SHIFT, `hold` = 0, counter = `WIDTH-1` (last bit on `dout`):**
  - With an accept: reload from `din`, counter := 0, `dout` := first bit of the new word, stay in SHIFT. This gives gap-free frames.
  - Without an accept: go to IDLE, `dout` := `IDLE_VAL`.
  - In both cases `done` pulses high on the next cycle.
- **SHIFT, `hold` = 1:** all registers hold, `dout` is stable, and no accept is possible.
- **`hold` in IDLE:** no effect; words are still accepted.
- **`busy`:** registered; equals (state == SHIFT).
- **`done`:** registered pulse; high for exactly one cycle per completed word, including back-to-back words.

## Timing
- **Reset (`QRT` = 0, asynchronous):**
  - State = IDLE, `dout` = `IDLE_VAL`, `busy` = 0, `done` = 0, counter = 0, shift register = 0.
  - `din_ready` = 1 while in reset as a combinational consequence of IDLE, but nothing is captured during reset.
- **Reset release:** synchronous release is handled upstream. The first accept is possible on the first rising edge with `QRT` = 1.
- **Latency:** word accepted at edge N gives bit k on `dout` during cycle N+1+k (with `hold` = 0), and `done` high during cycle N+1+`WIDTH`.
- **Throughput:** one word per `WIDTH` cycles. Sustained `din_valid` gives a continuous stream with no `IDLE_VAL` gap.
- **Hold:** each cycle of `hold` = 1 in SHIFT extends the frame by one cycle. `done` timing shifts by the same amount.
- **Reset mid-word:** the frame is aborted immediately, `dout` = `IDLE_VAL`, and no `done` is produced.
- **Boundaries:**
  - Counter wrap from `WIDTH-1` to 0 happens only on reload; otherwise the block goes to IDLE.
  - `WIDTH` = 2 must stream correctly.
  - Changing `din` while not ready has no effect.

## Structure
- Package `out_ser_pkg` holds:
  - the state enum `out_ser_state_t` (`S_IDLE`, `S_SHIFT`);
  - the counter-width function `cnt_w(WIDTH)`;
  - the `IDLE_VAL` default constant.
- One sub-module, `out_ser_shreg`: a loadable shift register with direction parameter, load and enable inputs, and a serial output tap.
- `out_ser` contains the FSM, counter, handshake and output registers. `dout` comes directly from a flop so it can pack next to the output buffer.

## Test plan
- **Reset:** `QRT` low with random inputs → `dout` = `IDLE_VAL`, `busy` = 0, `done` = 0, `din_ready` = 1. Reset release then accepting `din` = 8'hA5 (`MSB_FIRST`=1) → `dout` = 1,0,1,0,0,1,0,1 on cycles N+1..N+8; `done` at N+9; `dout` = 0 after.
- **LSB first:** `MSB_FIRST`=0, `din` = 8'h01 → `dout` = 1 then seven 0s.
- **Back-to-back:** `din_valid` held high with 8'hFF then 8'h00 → 16 contiguous bits (8 ones, 8 zeros) with no idle gap; `done` pulses at N+9 and N+17; `din_ready` high only in N+8 and N+16 within the stream.
- **Hold:** word 8'hF0, `hold` = 1 for 3 cycles during bit 2 → bit 2 lasts 4 cycles; `done` at N+12; `din_ready` stays 0 while held at the last bit.
- **Reset mid-word:** `QRT` pulsed low during bit 4 → `dout` = `IDLE_VAL` asynchronously, `busy` = 0, no `done`. The next word is then serialized correctly.
- **`WIDTH`=2:** stream of 2'b10, 2'b01 → `dout` = 1,0,0,1 contiguous; `done` every 2 cycles.
